fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Program-counter and next-address stage for the single-cycle core. Drives the
//  instruction memory address every cycle and selects the next PC from sequential,
//  branch-relative, absolute jump, or link-register return. Holds a one-entry link
//  register for call/return, and runs an IDLE/RUN/HALTED control FSM.
// PARAMETERS
//  ADDR_BITS   8     PC / instruction-memory address width (2**ADDR_BITS words)
//  RESET_ADDR  0     PC value loaded on reset and on restart
// PORTS
//  clk            in   1          rising-edge clock
//  reset          in   1          asynchronous, active-high reset
//  start          in   1          leave IDLE/HALTED and begin fetching at RESET_ADDR
//  stall          in   1          hold PC and link register this cycle
//  halt           in   1          stop fetching (decoded HALT instruction)
//  branch_taken   in   1          take PC-relative branch
//  branch_offset  in   ADDR_BITS  signed two's-complement offset from current PC
//  jump           in   1          absolute jump to jump_target
//  jump_target    in   ADDR_BITS  absolute jump destination
//  link           in   1          with jump: save address+1 into link register
//  ret            in   1          load PC from link register
//  address        out  ADDR_BITS  current PC, drives instruction memory address
//  pc_plus_one    out  ADDR_BITS  address+1 mod 2**ADDR_BITS (combinational)
//  link_addr      out  ADDR_BITS  link register contents
//  running        out  1          1 while in RUN
//  halted         out  1          1 while in HALTED
//  wrap           out  1          one-cycle pulse: sequential increment wrapped max->0
// BEHAVIOUR
//  Reset (async, immediate): address=RESET_ADDR, link_addr=0, state=IDLE,
//   running=0, halted=0, wrap=0. Deassertion takes effect on the next clk edge.
//  FSM: IDLE --start--> RUN; RUN --halt--> HALTED; HALTED --start--> RUN.
//   Entering RUN from IDLE/HALTED loads address=RESET_ADDR and clears link_addr.
//   In IDLE/HALTED, address and link_addr hold; all control inputs except start
//   are ignored.
//  In RUN, one update per rising edge, priority high->low:
//   halt   : state->HALTED, address holds (halting instruction stays presented)
//   stall  : address, link_addr hold
//   ret    : address <= link_addr
//   jump   : address <= jump_target; if link, link_addr <= pc_plus_one
//   branch_taken : address <= address + sign_ext(branch_offset), mod 2**ADDR_BITS
//   else   : address <= pc_plus_one
//  link without jump has no effect. ret with jump: ret wins, link ignored.
//  wrap=1 for exactly the cycle after a sequential step from 2**ADDR_BITS-1 to 0.
//   Jump, branch or ret landing on 0 does not assert wrap.
//  Latency: new address is visible right after the edge; the combinational
//   instruction memory returns the instruction in the same cycle (0-cycle fetch).
//  running = (state==RUN); halted = (state==HALTED); both registered with state.
//  Reset mid-RUN forces IDLE at once; the bench must see address=RESET_ADDR with
//   no clock edge.
// TESTING
//  1 reset, start pulse, 5 idle cycles -> address 0,1,2,3,4,5; running=1
//  2 address=0x10, branch_taken, offset=0xFD(-3) -> address 0x0D; offset 0x05 -> 0x12
//  3 address=0x20, jump+link, target=0x80 -> address 0x80, link_addr 0x21;
//    next cycle ret -> address 0x21
//  4 address=0xFF, no control -> address 0x00, wrap=1 for one cycle; jump to 0 -> wrap=0
//  5 halt+jump together at 0x40 -> address stays 0x40, halted=1; later stall/jump
//    ignored; start -> address 0x00, running=1, link_addr 0
//  6 stall 3 cycles at 0x07 -> 0x07 held; reset asserted mid-cycle -> address 0 at
//    once, IDLE

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - control and status bundle between the core and the fetch stage
interface fetch_unit_if #(
  parameter int unsigned ADDR_BITS = 8
);
  logic                 start;
  logic                 stall;
  logic                 halt;
  logic                 branch_taken;
  logic [ADDR_BITS-1:0] branch_offset;
  logic                 jump;
  logic [ADDR_BITS-1:0] jump_target;
  logic                 link;
  logic                 ret;
  logic [ADDR_BITS-1:0] address;
  logic [ADDR_BITS-1:0] pc_plus_one;
  logic [ADDR_BITS-1:0] link_addr;
  logic                 running;
  logic                 halted;
  logic                 wrap;

  // core side: issues control, observes the PC
  modport master (
    output start, stall, halt, branch_taken, branch_offset,
    output jump, jump_target, link, ret,
    input  address, pc_plus_one, link_addr, running, halted, wrap
  );

  // fetch stage side
  modport slave (
    input  start, stall, halt, branch_taken, branch_offset,
    input  jump, jump_target, link, ret,
    output address, pc_plus_one, link_addr, running, halted, wrap
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, next-address select, link register and run FSM
module fetch_unit #(
  parameter int unsigned          ADDR_BITS  = 8,
  parameter logic [ADDR_BITS-1:0] RESET_ADDR = '0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t               state, next_state;
  logic [ADDR_BITS-1:0] pc, next_pc;
  logic [ADDR_BITS-1:0] lr, next_lr;
  logic                 wrap_q, next_wrap;
  logic [ADDR_BITS-1:0] pc_inc;

  assign pc_inc = pc + 1'b1;

  // state, PC, link register and wrap flag; reset forces IDLE immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= RESET_ADDR;
      lr     <= '0;
      wrap_q <= 1'b0;
    end else begin
      state  <= next_state;
      pc     <= next_pc;
      lr     <= next_lr;
      wrap_q <= next_wrap;
    end
  end

  // next state and next PC selection, highest priority first
  always_comb begin
    next_state = state;
    next_pc    = pc;
    next_lr    = lr;
    next_wrap  = 1'b0;
    unique case (state)
      IDLE, HALTED: begin
        // only start is honoured while stopped; restart reloads the PC
        if (bus.start) begin
          next_state = RUN;
          next_pc    = RESET_ADDR;
          next_lr    = '0;
        end
      end
      RUN: begin
        if (bus.halt) begin
          // the halting instruction stays presented on the address bus
          next_state = HALTED;
        end else if (bus.stall) begin
          next_pc = pc;
        end else if (bus.ret) begin
          next_pc = lr;
        end else if (bus.jump) begin
          next_pc = bus.jump_target;
          if (bus.link) next_lr = pc_inc;
        end else if (bus.branch_taken) begin
          // same-width add gives sign-extended offset modulo 2**ADDR_BITS
          next_pc = pc + bus.branch_offset;
        end else begin
          next_pc   = pc_inc;
          next_wrap = (pc == {ADDR_BITS{1'b1}});
        end
      end
      default: begin
        next_state = IDLE;
        next_pc    = RESET_ADDR;
        next_lr    = '0;
      end
    endcase
  end

  assign bus.address     = pc;
  assign bus.pc_plus_one = pc_inc;
  assign bus.link_addr   = lr;
  assign bus.running     = (state == RUN);
  assign bus.halted      = (state == HALTED);
  assign bus.wrap        = wrap_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  fetch_unit_if #(.ADDR_BITS(8)) bus ();

  fetch_unit #(.ADDR_BITS(8), .RESET_ADDR(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_ctl();
    bus.start         = 1'b0;
    bus.stall         = 1'b0;
    bus.halt          = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_offset = 8'h00;
    bus.jump          = 1'b0;
    bus.jump_target   = 8'h00;
    bus.link          = 1'b0;
    bus.ret           = 1'b0;
  endtask

  // one rising edge, then settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_jump(input logic [7:0] tgt);
    clear_ctl();
    bus.jump        = 1'b1;
    bus.jump_target = tgt;
    step();
    clear_ctl();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    clear_ctl();
    reset = 1'b1;
    #2;
    check_eq("rst_addr", bus.address, 8'h00);
    check_eq("rst_link", bus.link_addr, 8'h00);
    check_eq("rst_running", bus.running, 1'b0);
    check_eq("rst_halted", bus.halted, 1'b0);
    check_eq("rst_wrap", bus.wrap, 1'b0);
    check_eq("rst_ppo", bus.pc_plus_one, 8'h01);

    step();
    reset = 1'b0;
    // IDLE ignores everything except start
    bus.jump = 1'b1; bus.jump_target = 8'h33;
    step();
    check_eq("idle_jump_ignored", bus.address, 8'h00);
    check_eq("idle_running", bus.running, 1'b0);
    clear_ctl();

    // 1: start then sequential fetch
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_eq("t1_addr0", bus.address, 8'h00);
    check_eq("t1_running", bus.running, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      step();
      check_eq($sformatf("t1_addr%0d", i), bus.address, 32'(i));
    end

    // 2: relative branches
    do_jump(8'h10);
    check_eq("t2_at10", bus.address, 8'h10);
    bus.branch_taken = 1'b1; bus.branch_offset = 8'hFD;
    step();
    check_eq("t2_back3", bus.address, 8'h0D);
    bus.branch_offset = 8'h05;
    step();
    check_eq("t2_fwd5", bus.address, 8'h12);
    clear_ctl();

    // 3: call and return
    do_jump(8'h20);
    bus.jump = 1'b1; bus.link = 1'b1; bus.jump_target = 8'h80;
    step();
    check_eq("t3_call_addr", bus.address, 8'h80);
    check_eq("t3_call_link", bus.link_addr, 8'h21);
    clear_ctl();
    bus.ret = 1'b1;
    step();
    check_eq("t3_ret_addr", bus.address, 8'h21);
    bus.jump = 1'b1; bus.link = 1'b1; bus.jump_target = 8'h55;
    step();
    check_eq("t3_retjump_addr", bus.address, 8'h21);
    check_eq("t3_retjump_link", bus.link_addr, 8'h21);
    clear_ctl();
    bus.link = 1'b1;
    step();
    check_eq("t3_linkonly_addr", bus.address, 8'h22);
    check_eq("t3_linkonly_link", bus.link_addr, 8'h21);
    clear_ctl();

    // 4: wrap flag only on sequential rollover
    do_jump(8'hFF);
    check_eq("t4_at_ff", bus.address, 8'hFF);
    check_eq("t4_nowrap_pre", bus.wrap, 1'b0);
    check_eq("t4_ppo_ff", bus.pc_plus_one, 8'h00);
    step();
    check_eq("t4_roll_addr", bus.address, 8'h00);
    check_eq("t4_wrap", bus.wrap, 1'b1);
    step();
    check_eq("t4_after_addr", bus.address, 8'h01);
    check_eq("t4_wrap_pulse", bus.wrap, 1'b0);
    do_jump(8'hFF);
    do_jump(8'h00);
    check_eq("t4_jump0_addr", bus.address, 8'h00);
    check_eq("t4_jump0_wrap", bus.wrap, 1'b0);
    do_jump(8'hFF);
    bus.branch_taken = 1'b1; bus.branch_offset = 8'h01;
    step();
    check_eq("t4_br0_addr", bus.address, 8'h00);
    check_eq("t4_br0_wrap", bus.wrap, 1'b0);
    clear_ctl();

    // 5: halt beats jump, halted ignores control, start restarts
    do_jump(8'h40);
    bus.halt = 1'b1; bus.jump = 1'b1; bus.jump_target = 8'h99;
    step();
    check_eq("t5_halt_addr", bus.address, 8'h40);
    check_eq("t5_halted", bus.halted, 1'b1);
    check_eq("t5_not_running", bus.running, 1'b0);
    clear_ctl();
    bus.stall = 1'b1; bus.jump = 1'b1; bus.jump_target = 8'h77;
    step();
    check_eq("t5_ignored_addr", bus.address, 8'h40);
    check_eq("t5_still_halted", bus.halted, 1'b1);
    clear_ctl();
    bus.start = 1'b1;
    step();
    clear_ctl();
    check_eq("t5_restart_addr", bus.address, 8'h00);
    check_eq("t5_restart_run", bus.running, 1'b1);
    check_eq("t5_restart_halted", bus.halted, 1'b0);
    check_eq("t5_restart_link", bus.link_addr, 8'h00);

    // 6: stall hold, then asynchronous reset mid-cycle
    bus.jump = 1'b1; bus.link = 1'b1; bus.jump_target = 8'h07;
    step();
    clear_ctl();
    check_eq("t6_at07", bus.address, 8'h07);
    check_eq("t6_link", bus.link_addr, 8'h01);
    bus.stall = 1'b1;
    bus.jump  = 1'b1; bus.jump_target = 8'h60;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("t6_stall%0d", i), bus.address, 8'h07);
    end
    clear_ctl();
    #2;
    reset = 1'b1;
    #1;
    check_eq("t6_async_addr", bus.address, 8'h00);
    check_eq("t6_async_link", bus.link_addr, 8'h00);
    check_eq("t6_async_running", bus.running, 1'b0);
    step();
    reset = 1'b0;
    step();
    check_eq("t6_idle_addr", bus.address, 8'h00);
    check_eq("t6_idle_running", bus.running, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
